// File: rtl/key_pkg.sv
// Shared definitions for the keypad event sequencer: key code width and FSM state encoding.
package key_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_HELD    = 2'b10,
        S_RELEASE = 2'b11
    } key_state_t;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO with a registered head output (no fall-through), sync clear and occupancy count.
module key_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CODE_W
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_en   = push && (!full || pop) && !clr;
    assign rd_en   = pop && !empty && !clr;
    assign rd_next = rd_en ? rd_ptr + PW'(1) : rd_ptr;

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // The head register bypasses the write data when the incoming entry becomes the new head.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_en && (wr_ptr == rd_next))
                dout <= din;
            else
                dout <= mem[rd_next];
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns the scanner's level key-valid into one event per physical press and queues events for a consumer.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int REL_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   key_en,
    input  logic [CODE_W-1:0]      key_code,
    input  logic                   clr,
    output logic [CODE_W-1:0]      code_out,
    output logic                   code_valid,
    input  logic                   code_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [1:0]             state_view
);

    localparam int RW = $clog2(REL_CYCLES);
    localparam logic [RW-1:0] REL_LAST = RW'(REL_CYCLES - 1);

    key_state_t        state;
    logic [RW-1:0]     rel_cnt;
    logic [CODE_W-1:0] cap_reg;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    assign push       = (state == S_CAPTURE);
    assign pop        = code_valid && code_ready;
    assign code_valid = !empty;
    assign state_view = state;

    // The release counter starts at 1 because the HELD->RELEASE edge already saw one low cycle.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            rel_cnt <= '0;
            cap_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_en) begin
                        cap_reg <= key_code;
                        state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: state <= S_HELD;
                S_HELD: begin
                    if (!key_en) begin
                        rel_cnt <= RW'(1);
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (key_en) begin
                        state <= S_HELD;
                    end else if (rel_cnt == REL_LAST) begin
                        rel_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        rel_cnt <= rel_cnt + RW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst)
            overflow <= 1'b0;
        else if (clr)
            overflow <= 1'b0;
        else if (push && full && !pop)
            overflow <= 1'b1;
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .CLK   (CLK),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (cap_reg),
        .dout  (code_out),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: press, bounce, overflow, full push+pop, clear and reset-mid-press.
`timescale 1ns/100ps
module tb_key_event_ctrl;

    logic       CLK = 1'b0;
    logic       rst;
    logic       key_en;
    logic [3:0] key_code;
    logic       clr;
    logic [3:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] count;
    logic       overflow;
    logic [1:0] state_view;

    int checks = 0;
    int errors = 0;

    key_event_ctrl #(.DEPTH(4), .REL_CYCLES(16)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .key_en     (key_en),
        .key_code   (key_code),
        .clr        (clr),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .count      (count),
        .overflow   (overflow),
        .state_view (state_view)
    );

    always #1 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic [3:0] code, input logic ready, input logic clr_v);
        key_en     = en;
        key_code   = code;
        code_ready = ready;
        clr        = clr_v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press_release(input logic [3:0] code, input logic ready);
        apply_stimulus(1'b1, code, ready, 1'b0);
        wait_cycles(3);
        apply_stimulus(1'b0, code, ready, 1'b0);
        wait_cycles(16);
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        wait_cycles(2);
        check_output("rst_state", state_view, 0);
        check_output("rst_count", count, 0);
        check_output("rst_valid", code_valid, 0);
        check_output("rst_code", code_out, 0);
        check_output("rst_ovf", overflow, 0);
        rst = 1'b1;
        wait_cycles(1);

        // single press with consumer ready
        apply_stimulus(1'b1, 4'h5, 1'b1, 1'b0);
        wait_cycles(1);
        check_output("t1_capture", state_view, 2'b01);
        check_output("t1_valid_early", code_valid, 0);
        wait_cycles(1);
        check_output("t1_valid", code_valid, 1);
        check_output("t1_code", code_out, 4'h5);
        check_output("t1_count1", count, 1);
        check_output("t1_held", state_view, 2'b10);
        wait_cycles(1);
        check_output("t1_popped", count, 0);
        wait_cycles(17);
        apply_stimulus(1'b0, 4'h5, 1'b1, 1'b0);
        wait_cycles(15);
        check_output("t1_rel_last", state_view, 2'b11);
        wait_cycles(1);
        check_output("t1_idle", state_view, 2'b00);
        check_output("t1_count0", count, 0);

        // release bounce: one event only
        apply_stimulus(1'b1, 4'h7, 1'b0, 1'b0);
        wait_cycles(2);
        check_output("t2_held", state_view, 2'b10);
        check_output("t2_code", code_out, 4'h7);
        apply_stimulus(1'b0, 4'h7, 1'b0, 1'b0);
        wait_cycles(1);
        check_output("t2_rel", state_view, 2'b11);
        wait_cycles(2);
        apply_stimulus(1'b1, 4'h9, 1'b0, 1'b0);
        wait_cycles(1);
        check_output("t2_reheld", state_view, 2'b10);
        wait_cycles(3);
        check_output("t2_no_event", count, 1);
        apply_stimulus(1'b0, 4'h9, 1'b0, 1'b0);
        wait_cycles(1);
        check_output("t2_rel2", state_view, 2'b11);
        wait_cycles(15);
        check_output("t2_idle", state_view, 2'b00);
        check_output("t2_count", count, 1);
        check_output("t2_head", code_out, 4'h7);
        apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);
        wait_cycles(1);
        check_output("t2_drain", code_valid, 0);

        // fill and overflow
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++)
            press_release(4'(i), 1'b0);
        check_output("t3_full", count, 4);
        check_output("t3_no_ovf", overflow, 0);
        press_release(4'h5, 1'b0);
        check_output("t3_count", count, 4);
        check_output("t3_ovf", overflow, 1);
        check_output("t3_head1", code_out, 4'h1);
        apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            wait_cycles(1);
            check_output("t3_head", code_out, 4'(i));
            check_output("t3_cnt", count, 3'(5 - i));
        end
        wait_cycles(1);
        check_output("t3_empty", code_valid, 0);
        check_output("t3_ovf_sticky", overflow, 1);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        wait_cycles(1);
        check_output("t3_ovf_clr", overflow, 0);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);

        // push and pop in the same cycle while full
        for (int i = 0; i < 4; i++)
            press_release(4'(4'hA + i), 1'b0);
        check_output("t4_full", count, 4);
        apply_stimulus(1'b1, 4'hE, 1'b0, 1'b0);
        wait_cycles(1);
        apply_stimulus(1'b1, 4'hE, 1'b1, 1'b0);
        wait_cycles(1);
        apply_stimulus(1'b1, 4'hE, 1'b0, 1'b0);
        check_output("t4_count", count, 4);
        check_output("t4_ovf", overflow, 0);
        check_output("t4_headB", code_out, 4'hB);
        apply_stimulus(1'b1, 4'hE, 1'b1, 1'b0);
        wait_cycles(1);
        check_output("t4_headC", code_out, 4'hC);
        wait_cycles(1);
        check_output("t4_headD", code_out, 4'hD);
        wait_cycles(1);
        check_output("t4_headE", code_out, 4'hE);
        check_output("t4_cnt1", count, 1);
        wait_cycles(1);
        check_output("t4_empty", count, 0);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        wait_cycles(16);

        // clear with three entries and the key still held
        press_release(4'h1, 1'b0);
        press_release(4'h2, 1'b0);
        apply_stimulus(1'b1, 4'h3, 1'b0, 1'b0);
        wait_cycles(2);
        check_output("t5_count3", count, 3);
        apply_stimulus(1'b1, 4'h3, 1'b0, 1'b1);
        wait_cycles(1);
        check_output("t5_clr_count", count, 0);
        check_output("t5_clr_valid", code_valid, 0);
        check_output("t5_clr_ovf", overflow, 0);
        check_output("t5_fsm_kept", state_view, 2'b10);
        apply_stimulus(1'b1, 4'h3, 1'b0, 1'b0);
        wait_cycles(4);
        check_output("t5_no_refire", count, 0);
        apply_stimulus(1'b0, 4'h3, 1'b0, 1'b0);
        wait_cycles(16);
        apply_stimulus(1'b1, 4'h8, 1'b0, 1'b0);
        wait_cycles(1);
        apply_stimulus(1'b1, 4'h8, 1'b0, 1'b1);
        wait_cycles(1);
        check_output("t5_push_clr", count, 0);
        apply_stimulus(1'b1, 4'h8, 1'b0, 1'b0);
        wait_cycles(2);
        check_output("t5_push_clr2", count, 0);
        apply_stimulus(1'b0, 4'h8, 1'b0, 1'b0);
        wait_cycles(16);

        // reset while held; key recaptured once afterwards
        apply_stimulus(1'b1, 4'h4, 1'b0, 1'b0);
        wait_cycles(2);
        check_output("t6_pre", count, 1);
        rst = 1'b0;
        #0.5;
        check_output("t6_state", state_view, 0);
        check_output("t6_count", count, 0);
        check_output("t6_valid", code_valid, 0);
        check_output("t6_code", code_out, 0);
        check_output("t6_ovf", overflow, 0);
        wait_cycles(1);
        rst = 1'b1;
        wait_cycles(2);
        check_output("t6_recap", count, 1);
        check_output("t6_code4", code_out, 4'h4);
        wait_cycles(3);
        check_output("t6_once", count, 1);
        apply_stimulus(1'b0, 4'h4, 1'b0, 1'b0);
        wait_cycles(16);
        check_output("t6_idle", state_view, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
